noc_vchannel_demux: RTL and testbench

- Receive side of a virtual-channel link. Accepts one shared flit bus qualified by a per-VC valid/ready pair, as driven by the link's VC multiplexer.
- Steers each accepted flit into a per-VC FIFO and presents each VC as an independent valid/ready stream.
- Buffering ensures a stalled consumer on one VC never blocks the other VCs on the shared link.
- Sits at a router input port or network-adapter ingress, directly after the physical link.

---
 rtl/noc_vchannel_pkg.sv | 16 +
 rtl/noc_vchannel_fifo.sv | 58 +++++
 rtl/noc_vchannel_demux.sv | 60 ++++++
 tb/tb_noc_vchannel_demux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_vchannel_pkg.sv
// Shared types and helpers for the virtual-channel link (mux and demux sides).
package noc_vchannel_pkg;

   localparam int unsigned LINK_FLIT_WIDTH = 32;

   typedef struct packed {
      logic                       last;
      logic [LINK_FLIT_WIDTH-1:0] flit;
   } flit_entry_t;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/noc_vchannel_fifo.sv
// Single-VC first-word-fall-through FIFO; ready reflects registered fullness only.
module noc_vchannel_fifo
   import noc_vchannel_pkg::*;
#(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ready,
   output logic             pop_valid,
   output logic [WIDTH-1:0] pop_data,
   input  logic             pop_ready
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = occ_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full, empty, push, pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign push = push_valid && !full;
   assign pop  = pop_ready && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign push_ready = !full;
   assign pop_valid  = !empty;
   assign pop_data   = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/noc_vchannel_demux.sv
// Receive side of a VC link: steers the shared flit bus into per-VC FIFOs.
module noc_vchannel_demux
   import noc_vchannel_pkg::*;
#(
   parameter int unsigned FLIT_WIDTH   = LINK_FLIT_WIDTH,
   parameter int unsigned CHANNELS     = 2,
   parameter int unsigned BUFFER_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [FLIT_WIDTH-1:0]                in_flit,
   input  logic                                 in_last,
   input  logic [CHANNELS-1:0]                  in_valid,
   output logic [CHANNELS-1:0]                  in_ready,
   output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
   output logic [CHANNELS-1:0]                  out_last,
   output logic [CHANNELS-1:0]                  out_valid,
   input  logic [CHANNELS-1:0]                  out_ready,
   output logic                                 err_multi_valid
);

   logic                  multi_valid;
   logic [CHANNELS-1:0]   push_valid;
   logic [FLIT_WIDTH:0]   fifo_out [CHANNELS];
   logic                  err_q;

   // Protocol violation: drop every push in the offending cycle.
   assign multi_valid = ($countones(in_valid) > 1);
   assign push_valid  = multi_valid ? '0 : in_valid;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
      noc_vchannel_fifo #(
         .WIDTH (FLIT_WIDTH + 1),
         .DEPTH (BUFFER_DEPTH)
      ) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .push_valid (push_valid[c]),
         .push_data  ({in_last, in_flit}),
         .push_ready (in_ready[c]),
         .pop_valid  (out_valid[c]),
         .pop_data   (fifo_out[c]),
         .pop_ready  (out_ready[c])
      );

      assign out_last[c] = fifo_out[c][FLIT_WIDTH];
      assign out_flit[c] = fifo_out[c][FLIT_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (multi_valid) begin
         err_q <= 1'b1;
      end
   end

   assign err_multi_valid = err_q;

endmodule

// File: tb/tb_noc_vchannel_demux.sv
// Scoreboard bench: per-VC expected queues filled on modelled accepts, drained on pops.
module tb_noc_vchannel_demux;

   localparam int unsigned W = 32;
   localparam int unsigned C = 2;
   localparam int unsigned D = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [W-1:0]         in_flit;
   logic                 in_last;
   logic [C-1:0]         in_valid;
   logic [C-1:0]         in_ready;
   logic [C-1:0][W-1:0]  out_flit;
   logic [C-1:0]         out_last;
   logic [C-1:0]         out_valid;
   logic [C-1:0]         out_ready;
   logic                 err_multi_valid;

   int checks = 0;
   int errors = 0;

   logic [W:0] sb [C][$];
   bit         acc [C];
   bit         err_m = 1'b0;
   bit         rand_rdy = 1'b0;

   noc_vchannel_demux #(
      .FLIT_WIDTH   (W),
      .CHANNELS     (C),
      .BUFFER_DEPTH (D)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_flit         (in_flit),
      .in_last         (in_last),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .out_flit        (out_flit),
      .out_last        (out_last),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .err_multi_valid (err_multi_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: checks outputs mid-cycle, then applies the coming edge.
   always @(negedge clk) begin : model
      logic [W:0] head;
      bit         single;
      for (int c = 0; c < C; c++) begin
         check("out_valid", out_valid[c], sb[c].size() > 0);
         check("in_ready", in_ready[c], sb[c].size() < D);
         if (sb[c].size() > 0) begin
            head = sb[c][0];
            check("out_flit", out_flit[c], head[W-1:0]);
            check("out_last", out_last[c], head[W]);
         end
      end
      check("err_multi_valid", err_multi_valid, err_m);
      if (rst) begin
         for (int c = 0; c < C; c++) begin
            sb[c].delete();
            acc[c] = 1'b0;
         end
         err_m = 1'b0;
      end else begin
         single = ($countones(in_valid) <= 1);
         if (!single) err_m = 1'b1;
         for (int c = 0; c < C; c++) begin
            acc[c] = in_valid[c] && single && (sb[c].size() < D);
            if (out_ready[c] && sb[c].size() > 0) void'(sb[c].pop_front());
            if (acc[c]) sb[c].push_back({in_last, in_flit});
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = C'($urandom_range(0, (1 << C) - 1));
   endtask

   task automatic send(input int c, input logic [W-1:0] f, input logic l);
      bit done = 1'b0;
      in_flit     = f;
      in_last     = l;
      in_valid    = '0;
      in_valid[c] = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk);
         done = acc[c];
         #1;
         if (rand_rdy) out_ready = C'($urandom_range(0, (1 << C) - 1));
      end
      in_valid = '0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      bit empty_all = 1'b0;
      out_ready = '1;
      for (int i = 0; i < 50 && !empty_all; i++) begin
         cycle();
         empty_all = (sb[0].size() == 0) && (sb[1].size() == 0);
      end
      if (!empty_all) check("drain_timeout", 0, 1);
   endtask

   initial begin
      rst       = 1'b1;
      in_flit   = '0;
      in_last   = 1'b0;
      in_valid  = '0;
      out_ready = '0;
      cycle();
      cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 2'b00);
      check("rst_in_ready", in_ready, 2'b11);
      check("rst_err", err_multi_valid, 1'b0);

      // Single flit with one-cycle fall-through.
      @(posedge clk); #1;
      send(0, 32'hA5, 1'b1);
      @(negedge clk);
      check("single_valid", out_valid, 2'b01);
      check("single_flit", out_flit[0], 32'hA5);
      check("single_last", out_last[0], 1'b1);
      out_ready[0] = 1'b1;
      cycle();
      @(negedge clk);
      check("single_popped", out_valid[0], 1'b0);
      out_ready = '0;

      // Fill VC1, hold a fifth flit, then release the consumer.
      for (int i = 1; i <= 4; i++) send(1, W'(i), i == 4);
      @(negedge clk);
      check("fill_in_ready", in_ready, 2'b01);
      fork
         send(1, 32'h5, 1'b1);
         begin
            repeat (3) @(negedge clk);
            check("stall_head", out_flit[1], 32'h1);
            check("stall_ready", in_ready[1], 1'b0);
            @(posedge clk); #1;
            out_ready[1] = 1'b1;
         end
      join
      drain();
      out_ready = '0;

      // Full VC0 with concurrent pop: first edge pops only.
      for (int i = 0; i < 4; i++) send(0, 32'h30 + W'(i), 1'b0);
      out_ready[0] = 1'b1;
      in_flit      = 32'h34;
      in_last      = 1'b1;
      in_valid     = 2'b01;
      @(negedge clk);
      check("full_pop_rdy0", in_ready[0], 1'b0);
      @(negedge clk);
      check("full_pop_rdy1", in_ready[0], 1'b1);
      check("full_pop_head", out_flit[0], 32'h31);
      @(posedge clk); #1;
      in_valid = '0;
      drain();

      // Interleaved packets with random consumer back-pressure.
      rand_rdy = 1'b1;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 3; i++) send(0, 32'h10 + W'(i), i == 2);
         for (int i = 0; i < 3; i++) send(1, 32'h20 + W'(i), i == 2);
      end
      rand_rdy = 1'b0;
      drain();

      // Multi-valid: nothing written, sticky error.
      out_ready = '0;
      in_flit   = 32'hEE;
      in_valid  = 2'b11;
      cycle();
      in_valid = '0;
      @(negedge clk);
      check("multi_err", err_multi_valid, 1'b1);
      check("multi_no_push", out_valid, 2'b00);
      repeat (3) cycle();
      @(negedge clk);
      check("multi_sticky", err_multi_valid, 1'b1);

      // Reset mid-operation discards buffered flits and clears the error.
      send(0, 32'h40, 1'b0);
      send(0, 32'h41, 1'b0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", out_valid, 2'b00);
      check("mid_rst_ready", in_ready, 2'b11);
      check("mid_rst_err", err_multi_valid, 1'b0);
      @(posedge clk); #1;
      send(0, 32'h50, 1'b1);
      @(negedge clk);
      check("post_rst_valid", out_valid[0], 1'b1);
      check("post_rst_flit", out_flit[0], 32'h50);
      drain();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
